// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding,
// {CKP,CPH} mode constants and the default word width.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_SHIFT = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  localparam logic [1:0] MODO0 = 2'b00;
  localparam logic [1:0] MODO1 = 2'b01;
  localparam logic [1:0] MODO2 = 2'b10;
  localparam logic [1:0] MODO3 = 2'b11;

  // Clock phase of a {CKP,CPH} mode: 1 means MOSI launches on the leading
  // edge and MISO is captured on the trailing edge.
  function automatic logic mode_cph(input logic [1:0] mode);
    logic r_cph;
    case (mode)
      MODO0, MODO2: r_cph = 1'b0;
      MODO1, MODO3: r_cph = 1'b1;
      default:      r_cph = 1'b0;
    endcase
    return r_cph;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: DIV-cycle half-period divider that toggles SCK at the end
// of each half-period while enabled, and reports which edge that was.
module spi_sck_gen #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_idle_lvl,
  output logic o_sck,
  output logic o_lead_stb,
  output logic o_trail_stb,
  output logic o_half_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          r_trail;   // next edge produced is a trailing edge

  assign o_half_done = i_en && (r_cnt == HALF_LAST);
  assign o_lead_stb  = o_half_done && !r_trail;
  assign o_trail_stb = o_half_done && r_trail;
  assign o_sck       = r_sck;

  // Divider counter and SCK toggle; SCK parks at the idle level when disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_sck   <= 1'b0;
      r_trail <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_sck   <= i_idle_lvl;
      r_trail <= 1'b0;
    end else if (o_half_done) begin
      r_cnt   <= '0;
      r_sck   <= ~r_sck;
      r_trail <= ~r_trail;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/transmisor_spi.sv
// Full-duplex SPI master: shifts one DATA_W word out on MOSI (MSB first)
// while capturing DATA_W bits from MISO, in any of the four CKP/CPH modes.
module transmisor_spi
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV    = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              CKP,
  input  logic              CPH,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              MISO,
  output logic              SCK,
  output logic              SS,
  output logic              MOSI,
  output logic              trans,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] DATA_OUT
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_tx, r_rx, r_dout;
  logic [1:0]        r_mode;
  logic              r_mosi, r_ss, r_trans, r_busy, r_done;

  logic w_sck, w_lead_stb, w_trail_stb, w_half_done;
  logic w_cnt_last, w_last_bit, w_accept, w_finish, w_cph, w_idle_lvl;

  assign w_cnt_last = (r_cnt == PH_LAST);
  assign w_last_bit = (r_bit == BIT_LAST);
  assign w_accept   = (r_state == ST_IDLE) && START;
  assign w_finish   = (r_state == ST_HOLD) && w_cnt_last;
  assign w_cph      = mode_cph(r_mode);
  // SCK follows the live CKP input only while idle; afterwards the latched one.
  assign w_idle_lvl = (r_state == ST_IDLE) ? CKP : r_mode[1];

  spi_sck_gen #(.DIV(DIV)) u_sck_gen (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_en        (r_state == ST_SHIFT),
    .i_idle_lvl  (w_idle_lvl),
    .o_sck       (w_sck),
    .o_lead_stb  (w_lead_stb),
    .o_trail_stb (w_trail_stb),
    .o_half_done (w_half_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: SETUP and HOLD last DIV cycles, SHIFT ends on the last trailing edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_next = ST_SETUP;
      ST_SETUP: if (w_cnt_last) w_next = ST_SHIFT;
      ST_SHIFT: if (w_trail_stb && w_last_bit) w_next = ST_HOLD;
      ST_HOLD:  if (w_cnt_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered handshake/pin controls and the SETUP/HOLD phase counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ss    <= 1'b1;
      r_trans <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ss    <= (w_next == ST_IDLE);
      r_trans <= (w_next != ST_IDLE);
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= w_finish;
      if (((r_state == ST_SETUP) || (r_state == ST_HOLD)) && !w_cnt_last)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  // Shift registers, MOSI, bit counter and received-word register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_mode <= MODO0;
      r_bit  <= '0;
      r_mosi <= 1'b0;
    end else if (w_accept) begin
      r_tx   <= DATA_IN;
      r_rx   <= '0;
      r_mode <= {CKP, CPH};
      r_bit  <= '0;
      r_mosi <= CPH ? 1'b0 : DATA_IN[DATA_W-1];
    end else if (w_half_done) begin
      if (w_lead_stb) begin
        if (w_cph) begin
          r_mosi <= r_tx[DATA_W-1];
          r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
        end else begin
          r_rx   <= {r_rx[DATA_W-2:0], MISO};
        end
      end else begin
        r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
        if (w_cph) begin
          r_rx <= {r_rx[DATA_W-2:0], MISO};
        end else if (!w_last_bit) begin
          r_mosi <= r_tx[DATA_W-2];
          r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
        end
      end
    end else if (w_finish) begin
      r_dout <= r_rx;
      r_mosi <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_mosi <= 1'b0;
    end
  end

  assign SCK      = w_sck;
  assign SS       = r_ss;
  assign MOSI     = r_mosi;
  assign trans    = r_trans;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign DATA_OUT = r_dout;

endmodule

// File: tb/tb_transmisor_spi.sv
// Scoreboard bench for transmisor_spi: the driver pushes the expected result
// of each transfer, a bus monitor (which also plays the SPI slave) pops and
// checks it when DONE pulses.
module tb_transmisor_spi;

  localparam int W       = 16;
  localparam int DIV     = 2;
  localparam int SS_LEN  = 68;
  localparam int N_EDGES = 32;

  logic         CLK = 1'b0;
  logic         RESET, START, CKP, CPH, MISO;
  logic [W-1:0] DATA_IN;
  logic         SCK, SS, MOSI, trans, BUSY, DONE;
  logic [W-1:0] DATA_OUT;

  always #5 CLK = ~CLK;

  transmisor_spi #(.DATA_W(W), .DIV(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CKP(CKP), .CPH(CPH),
    .DATA_IN(DATA_IN), .MISO(MISO), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .trans(trans), .BUSY(BUSY), .DONE(DONE), .DATA_OUT(DATA_OUT)
  );

  typedef struct {
    logic [W-1:0] dout;
    logic [W-1:0] mosi;
    logic         ckp;
    int           gap;   // required SS-high gap before this transfer, -1 = don't care
  } exp_t;

  exp_t         q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic         m_cph  = 1'b0;
  logic [W-1:0] m_miso_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor + slave model + scoreboard checker.
  initial begin
    logic         in_win, prev_sck, prev_done, lead;
    logic [W-1:0] cap, sreg;
    int           ss_len, edges, gap_cnt, last_gap;
    exp_t         e;
    in_win = 0; prev_sck = 0; prev_done = 0; cap = '0; sreg = '0;
    ss_len = 0; edges = 0; gap_cnt = 0; last_gap = 0;
    MISO = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (!RESET) begin
        in_win = 0; gap_cnt = 0; prev_done = 0; prev_sck = SCK; MISO = 1'b0;
        continue;
      end
      if (prev_done) chk("done_width", DONE, 1'b0);
      if (!SS) begin
        if (!in_win) begin
          in_win = 1; ss_len = 0; edges = 0; cap = '0;
          last_gap = gap_cnt; prev_sck = SCK;
          sreg = m_miso_word;
          MISO = m_cph ? 1'b0 : sreg[W-1];
        end
        ss_len++;
        if (SCK != prev_sck) begin
          edges++;
          lead = edges[0];
          if (lead != m_cph) cap = {cap[W-2:0], MOSI};
          if (m_cph && lead) begin
            MISO = sreg[W-1];
            sreg = {sreg[W-2:0], 1'b0};
          end else if (!m_cph && !lead) begin
            sreg = {sreg[W-2:0], 1'b0};
            MISO = sreg[W-1];
          end
        end
      end else begin
        if (in_win) begin in_win = 0; gap_cnt = 0; end
        gap_cnt++;
      end
      prev_sck = SCK;
      if (DONE) begin
        if (q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_done: got DONE=1, expected no transfer");
        end else begin
          e = q.pop_front();
          chk("data_out", DATA_OUT, e.dout);
          chk("mosi_bits", cap, e.mosi);
          chk("ss_low_cycles", ss_len, SS_LEN);
          chk("sck_edges", edges, N_EDGES);
          chk("busy_after", BUSY, 1'b0);
          chk("trans_after", trans, 1'b0);
          chk("sck_idle", SCK, e.ckp);
          if (e.gap >= 0) chk("ss_gap", last_gap, e.gap);
        end
      end
      prev_done = DONE;
    end
  end

  task automatic set_mode(input logic ckp, input logic cph, input logic [W-1:0] din,
                          input logic [W-1:0] sword);
    @(negedge CLK);
    CKP = ckp; CPH = cph; DATA_IN = din;
    m_cph = cph; m_miso_word = sword;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (BUSY) return;
    end
    n_vec++; n_miss++;
    $display("FAIL busy_timeout: got BUSY=0, expected 1");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (DONE) return;
    end
    n_vec++; n_miss++;
    $display("FAIL done_timeout: got DONE=0, expected 1");
  endtask

  task automatic start_xfer(input logic ckp, input logic cph, input logic [W-1:0] din,
                            input logic [W-1:0] sword);
    set_mode(ckp, cph, din, sword);
    START = 1'b1;
    wait_busy();
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic xfer(input logic ckp, input logic cph, input logic [W-1:0] din,
                      input logic [W-1:0] sword, input logic [W-1:0] exp_dout,
                      input bit perturb);
    exp_t e;
    e.dout = exp_dout; e.mosi = din; e.ckp = ckp; e.gap = -1;
    q.push_back(e);
    start_xfer(ckp, cph, din, sword);
    if (perturb) begin
      repeat (20) @(negedge CLK);
      CKP = ~ckp; CPH = ~cph; DATA_IN = ~din;
      repeat (15) @(negedge CLK);
      CKP = ckp; CPH = ~cph; DATA_IN = 16'h5555;
    end
    wait_done();
    @(negedge CLK);
    CKP = ckp; CPH = cph; DATA_IN = din;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RESET = 1'b1; START = 1'b0; CKP = 1'b0; CPH = 1'b0; DATA_IN = '0;
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ss", SS, 1'b1);
    chk("rst_trans", trans, 1'b0);
    chk("rst_sck", SCK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_data_out", DATA_OUT, 16'h0000);
    @(negedge CLK) RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Mode 0 reference transfer
    xfer(1'b0, 1'b0, 16'h0702, 16'hA5C3, 16'hA5C3, 1'b0);

    // Abort after 7 bits of a mode-0 transfer
    chk("dout_before_abort", DATA_OUT, 16'hA5C3);
    start_xfer(1'b0, 1'b0, 16'h0702, 16'hA5C3);
    repeat (29) @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    chk("abort_ss", SS, 1'b1);
    chk("abort_trans", trans, 1'b0);
    chk("abort_sck", SCK, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_data_out", DATA_OUT, 16'h0000);
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_no_done", DONE, 1'b0);
    @(negedge CLK) RESET = 1'b1;
    repeat (2) @(negedge CLK);
    xfer(1'b0, 1'b0, 16'h0702, 16'hA5C3, 16'hA5C3, 1'b0);

    // Mode 3
    xfer(1'b1, 1'b1, 16'h8001, 16'h8001, 16'h8001, 1'b0);

    // Modes 1 and 2, MISO held high
    xfer(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    xfer(1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
    xfer(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    xfer(1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);

    // Back-to-back transfers with START held high
    set_mode(1'b0, 1'b0, 16'h1234, 16'h5A5A);
    for (int i = 0; i < 3; i++) begin
      e.dout = 16'h5A5A; e.mosi = 16'h1234; e.ckp = 1'b0; e.gap = (i == 0) ? -1 : 1;
      q.push_back(e);
    end
    START = 1'b1;
    wait_done();
    wait_done();
    wait_busy();
    @(negedge CLK) START = 1'b0;
    repeat (10) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK) START = 1'b0;
    wait_done();
    repeat (20) @(posedge CLK);
    #1;
    chk("no_extra_ss", SS, 1'b1);
    chk("no_extra_busy", BUSY, 1'b0);

    // Mode and data inputs toggled mid-transfer
    xfer(1'b0, 1'b0, 16'h0702, 16'hA5C3, 16'hA5C3, 1'b1);

    repeat (5) @(posedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
